// File: rtl/mrv1_imt_sched.sv
// mrv1_imt_sched: interleaved multithreading fetch scheduler.
// Keeps per-thread active/stalled/PC state and grants one eligible thread per
// accepted fetch, rotating round-robin from the thread after the last grant.
// Optional feature: define MRV1_IMT_WSTALL_EN to enable per-thread wait-stall
// parking (wstall/wake). Without it, those inputs are ignored and no stall
// state exists.
module mrv1_imt_sched #(
  parameter int          NUM_TW_P   = 8,
  parameter logic [31:0] RESET_PC_P = 32'h0000_0000,
  localparam int         TID        = $clog2(NUM_TW_P)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  output logic                sched_vld_o,
  input  logic                sched_rdy_i,
  output logic [TID-1:0]      sched_tid_o,
  output logic [31:0]         sched_pc_o,
  input  logic                dec_j_pc_vld_i,
  input  logic [TID-1:0]      dec_tid_i,
  input  logic [31:0]         dec_j_pc_i,
  input  logic                exec_b_pc_vld_i,
  input  logic [TID-1:0]      exec_tid_i,
  input  logic [31:0]         exec_b_pc_i,
  input  logic                wstall_vld_i,
  input  logic [TID-1:0]      wstall_tid_i,
  input  logic                wake_vld_i,
  input  logic [TID-1:0]      wake_tid_i,
  input  logic                th_ctl_tspawn_vld_i,
  input  logic                th_ctl_texit_vld_i,
  input  logic [TID-1:0]      th_ctl_tid_i,
  input  logic [31:0]         th_ctl_tspawn_pc_i,
  output logic [NUM_TW_P-1:0] active_mask_o
);

  localparam logic [NUM_TW_P-1:0] ONE_HOT0 = {{(NUM_TW_P-1){1'b0}}, 1'b1};

  logic [NUM_TW_P-1:0] active;
  logic [NUM_TW_P-1:0] stalled;
  logic [NUM_TW_P-1:0] eligible;
  logic [31:0]         pc [NUM_TW_P];
  logic [TID-1:0]      last_grant;

  logic [TID-1:0]      grant;
  logic [TID-1:0]      probe;
  logic                found;
  logic                issue;

  logic [NUM_TW_P-1:0] spawn_sel;
  logic [NUM_TW_P-1:0] exit_sel;
  logic [NUM_TW_P-1:0] exec_sel;
  logic [NUM_TW_P-1:0] dec_sel;
  logic [NUM_TW_P-1:0] issue_sel;

  // Decode the one-hot per-thread update selects; redirects only hit active threads.
  always_comb begin
    spawn_sel = th_ctl_tspawn_vld_i ? (ONE_HOT0 << th_ctl_tid_i) : '0;
    exit_sel  = th_ctl_texit_vld_i  ? (ONE_HOT0 << th_ctl_tid_i) : '0;
    exec_sel  = exec_b_pc_vld_i     ? ((ONE_HOT0 << exec_tid_i) & active) : '0;
    dec_sel   = dec_j_pc_vld_i      ? ((ONE_HOT0 << dec_tid_i) & active) : '0;
    issue_sel = issue               ? (ONE_HOT0 << grant) : '0;
  end

  // Round-robin search starting one past the last grant, wrapping naturally in TID bits.
  always_comb begin
    grant = last_grant;
    probe = last_grant;
    found = 1'b0;
    for (int i = 1; i <= NUM_TW_P; i++) begin
      probe = last_grant + TID'(i);
      if (!found && eligible[probe]) begin
        found = 1'b1;
        grant = probe;
      end
    end
  end

  assign eligible      = active & ~stalled;
  assign sched_vld_o   = |eligible;
  assign sched_tid_o   = grant;
  assign sched_pc_o    = pc[grant];
  assign issue         = sched_vld_o & sched_rdy_i;
  assign active_mask_o = active;

  // Thread liveness: spawn sets, exit clears, spawn wins on a collision.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      active <= ONE_HOT0;
    end else begin
      active <= (active & ~exit_sel) | spawn_sel;
    end
  end

`ifdef MRV1_IMT_WSTALL_EN
  logic [NUM_TW_P-1:0] stall_sel;
  logic [NUM_TW_P-1:0] wake_sel;

  assign stall_sel = wstall_vld_i ? (ONE_HOT0 << wstall_tid_i) : '0;
  assign wake_sel  = wake_vld_i   ? (ONE_HOT0 << wake_tid_i)   : '0;

  // Park/unpark threads; a fresh spawn or a wake always leaves the thread runnable.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stalled <= '0;
    end else begin
      stalled <= (stalled | stall_sel) & ~wake_sel & ~spawn_sel;
    end
  end
`else
  logic unused_stall_inputs;

  assign stalled             = '0;
  assign unused_stall_inputs = ^{wstall_vld_i, wstall_tid_i, wake_vld_i, wake_tid_i};
`endif

  // Per-thread PC: spawn beats exec redirect beats decode redirect beats fetch increment.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int t = 0; t < NUM_TW_P; t++) begin
        pc[t] <= (t == 0) ? RESET_PC_P : 32'h0;
      end
    end else begin
      for (int t = 0; t < NUM_TW_P; t++) begin
        if (spawn_sel[t]) begin
          pc[t] <= th_ctl_tspawn_pc_i;
        end else if (exec_sel[t]) begin
          pc[t] <= exec_b_pc_i;
        end else if (dec_sel[t]) begin
          pc[t] <= dec_j_pc_i;
        end else if (issue_sel[t]) begin
          pc[t] <= pc[t] + 32'd4;
        end
      end
    end
  end

  // Remember the issued thread so the next search starts just after it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_grant <= TID'(NUM_TW_P - 1);
    end else if (issue) begin
      last_grant <= grant;
    end
  end

endmodule

// File: tb/tb_mrv1_imt_sched.sv
// tb_mrv1_imt_sched: scoreboard bench for the IMT fetch scheduler.
// Expected grants are queued as stimulus is driven and compared whenever the
// scheduler issues a fetch. The stall scenario follows MRV1_IMT_WSTALL_EN.
module tb_mrv1_imt_sched;

  localparam int NUM_TW = 8;
  localparam int TIDW   = 3;

  typedef struct {
    logic [TIDW-1:0] tid;
    logic [31:0]     pc;
  } exp_t;

  logic              clk;
  logic              rstN;
  logic              schedVld;
  logic              schedRdy;
  logic [TIDW-1:0]   schedTid;
  logic [31:0]       schedPc;
  logic              decVld;
  logic [TIDW-1:0]   decTid;
  logic [31:0]       decPc;
  logic              execVld;
  logic [TIDW-1:0]   execTid;
  logic [31:0]       execPc;
  logic              wstallVld;
  logic [TIDW-1:0]   wstallTid;
  logic              wakeVld;
  logic [TIDW-1:0]   wakeTid;
  logic              spawnVld;
  logic              exitVld;
  logic [TIDW-1:0]   ctlTid;
  logic [31:0]       spawnPc;
  logic [NUM_TW-1:0] activeMask;

  exp_t expQ[$];
  exp_t monExp;
  int   checkCount = 0;
  int   passCount  = 0;

  mrv1_imt_sched #(
    .NUM_TW_P  (NUM_TW),
    .RESET_PC_P(32'h0000_0000)
  ) dut (
    .clk_i              (clk),
    .rst_ni             (rstN),
    .sched_vld_o        (schedVld),
    .sched_rdy_i        (schedRdy),
    .sched_tid_o        (schedTid),
    .sched_pc_o         (schedPc),
    .dec_j_pc_vld_i     (decVld),
    .dec_tid_i          (decTid),
    .dec_j_pc_i         (decPc),
    .exec_b_pc_vld_i    (execVld),
    .exec_tid_i         (execTid),
    .exec_b_pc_i        (execPc),
    .wstall_vld_i       (wstallVld),
    .wstall_tid_i       (wstallTid),
    .wake_vld_i         (wakeVld),
    .wake_tid_i         (wakeTid),
    .th_ctl_tspawn_vld_i(spawnVld),
    .th_ctl_texit_vld_i (exitVld),
    .th_ctl_tid_i       (ctlTid),
    .th_ctl_tspawn_pc_i (spawnPc),
    .active_mask_o      (activeMask)
  );

  // Free-running clock, 10 time-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic pushExp(input logic [TIDW-1:0] tid, input logic [31:0] pc);
    exp_t e;
    e.tid = tid;
    e.pc  = pc;
    expQ.push_back(e);
  endtask

  // Advance n cycles; one-shot control pulses are dropped after the first edge.
  task automatic applyStimulus(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      decVld    = 1'b0;
      execVld   = 1'b0;
      wstallVld = 1'b0;
      wakeVld   = 1'b0;
      spawnVld  = 1'b0;
      exitVld   = 1'b0;
    end
  endtask

  task automatic spawnThread(input logic [TIDW-1:0] tid, input logic [31:0] pc);
    spawnVld = 1'b1;
    ctlTid   = tid;
    spawnPc  = pc;
  endtask

  task automatic exitThread(input logic [TIDW-1:0] tid);
    exitVld = 1'b1;
    ctlTid  = tid;
  endtask

  // Compare every accepted fetch against the oldest queued expectation.
  always @(negedge clk) begin
    if (rstN && schedVld && schedRdy) begin
      checkOutput("sb_avail", 64'(expQ.size() != 0), 64'd1);
      if (expQ.size() != 0) begin
        monExp = expQ.pop_front();
        checkOutput("grant_tid", 64'(schedTid), 64'(monExp.tid));
        checkOutput("grant_pc", 64'(schedPc), 64'(monExp.pc));
      end
    end
  end

  initial begin
    rstN = 1'b0; schedRdy = 1'b0;
    decVld = 1'b0; decTid = '0; decPc = '0;
    execVld = 1'b0; execTid = '0; execPc = '0;
    wstallVld = 1'b0; wstallTid = '0; wakeVld = 1'b0; wakeTid = '0;
    spawnVld = 1'b0; exitVld = 1'b0; ctlTid = '0; spawnPc = '0;

    repeat (2) @(posedge clk);
    #2;
    checkOutput("rst_vld", 64'(schedVld), 64'd1);
    checkOutput("rst_tid", 64'(schedTid), 64'd0);
    checkOutput("rst_pc", 64'(schedPc), 64'h0);
    checkOutput("rst_mask", 64'(activeMask), 64'h01);
    @(posedge clk);
    #1;

    // Boot: thread 0 alone, sequential PCs.
    rstN = 1'b1;
    schedRdy = 1'b1;
    pushExp(0, 32'h0); pushExp(0, 32'h4); pushExp(0, 32'h8);
    applyStimulus(3);
    checkOutput("boot_mask", 64'(activeMask), 64'h01);

    // Spawn 3 and 5 while thread 0 keeps fetching; rotation 0,3,5,0,3.
    pushExp(0, 32'hC);
    spawnThread(3, 32'h100);
    applyStimulus(1);
    pushExp(3, 32'h100);
    spawnThread(5, 32'h200);
    applyStimulus(1);
    pushExp(5, 32'h200); pushExp(0, 32'h10); pushExp(3, 32'h104);
    applyStimulus(3);
    schedRdy = 1'b0;
    checkOutput("spawn_mask", 64'(activeMask), 64'h29);

    // Exec and decode redirect on the thread being issued: exec wins.
    schedRdy = 1'b1;
    pushExp(5, 32'h204);
    applyStimulus(1);
    pushExp(0, 32'h14);
    applyStimulus(1);
    pushExp(3, 32'h108);
    execVld = 1'b1; execTid = 3; execPc = 32'h400;
    decVld  = 1'b1; decTid  = 3; decPc  = 32'h500;
    applyStimulus(1);
    pushExp(5, 32'h208); pushExp(0, 32'h18); pushExp(3, 32'h400);
    applyStimulus(3);
    schedRdy = 1'b0;

    // Redirects to two different threads in one cycle, plus one to an inactive thread.
    execVld = 1'b1; execTid = 5; execPc = 32'h600;
    decVld  = 1'b1; decTid  = 0; decPc  = 32'h700;
    applyStimulus(1);
    execVld = 1'b1; execTid = 2; execPc = 32'h800;
    applyStimulus(1);
    checkOutput("inactive_redir_mask", 64'(activeMask), 64'h29);
    schedRdy = 1'b1;
    pushExp(5, 32'h600);
    applyStimulus(1);
    pushExp(0, 32'h700);
    decVld = 1'b1; decTid = 0; decPc = 32'h780;
    applyStimulus(1);
    pushExp(3, 32'h404); pushExp(5, 32'h604); pushExp(0, 32'h780);
    applyStimulus(3);
    schedRdy = 1'b0;

    // Backpressure: four idle cycles must leave PCs and pointer untouched.
    applyStimulus(4);
    checkOutput("hold_vld", 64'(schedVld), 64'd1);
    checkOutput("hold_tid", 64'(schedTid), 64'd3);
    checkOutput("hold_pc", 64'(schedPc), 64'h408);
    schedRdy = 1'b1;
    pushExp(3, 32'h408);
    applyStimulus(1);
    schedRdy = 1'b0;

    // Retire 5 and 3, then bring 3 back at a fresh PC.
    exitThread(5);
    applyStimulus(1);
    exitThread(3);
    applyStimulus(1);
    checkOutput("exit_mask", 64'(activeMask), 64'h01);
    spawnThread(3, 32'h900);
    applyStimulus(1);

`ifdef MRV1_IMT_WSTALL_EN
    wstallVld = 1'b1; wstallTid = 0;
    applyStimulus(1);
    schedRdy = 1'b1;
    pushExp(3, 32'h900); pushExp(3, 32'h904); pushExp(3, 32'h908);
    applyStimulus(3);
    schedRdy = 1'b0;
    wakeVld = 1'b1; wakeTid = 0;
    applyStimulus(1);
    schedRdy = 1'b1;
    pushExp(0, 32'h784);
    wstallVld = 1'b1; wstallTid = 0;
    applyStimulus(1);
    pushExp(3, 32'h90C); pushExp(3, 32'h910);
    applyStimulus(2);
    schedRdy = 1'b0;
    wstallVld = 1'b1; wstallTid = 0;
    wakeVld   = 1'b1; wakeTid   = 0;
    applyStimulus(1);
    schedRdy = 1'b1;
    pushExp(0, 32'h788); pushExp(3, 32'h914);
    applyStimulus(2);
    schedRdy = 1'b0;
`else
    wstallVld = 1'b1; wstallTid = 0;
    applyStimulus(1);
    schedRdy = 1'b1;
    pushExp(0, 32'h784); pushExp(3, 32'h900); pushExp(0, 32'h788);
    applyStimulus(3);
    schedRdy = 1'b0;
`endif

    // Exit everything: no request, and ready alone must not change state.
    exitThread(3);
    applyStimulus(1);
    exitThread(0);
    applyStimulus(1);
    checkOutput("idle_vld", 64'(schedVld), 64'd0);
    checkOutput("idle_mask", 64'(activeMask), 64'h00);
    schedRdy = 1'b1;
    applyStimulus(3);
    schedRdy = 1'b0;

    // PC wraps modulo 2^32.
    spawnThread(0, 32'hFFFF_FFFC);
    applyStimulus(1);
    schedRdy = 1'b1;
    pushExp(0, 32'hFFFF_FFFC); pushExp(0, 32'h0000_0000);
    applyStimulus(2);
    schedRdy = 1'b0;

    // Spawn beats exit on the same thread; exit on the issued thread keeps the issue.
    spawnThread(6, 32'hA00);
    exitVld = 1'b1;
    applyStimulus(1);
    checkOutput("spawn_over_exit_mask", 64'(activeMask), 64'h41);
    schedRdy = 1'b1;
    pushExp(6, 32'hA00);
    exitThread(6);
    applyStimulus(1);
    schedRdy = 1'b0;
    checkOutput("exit_issued_mask", 64'(activeMask), 64'h01);

    // Spawning an already-active thread overwrites its PC.
    spawnThread(0, 32'hB00);
    applyStimulus(1);
    schedRdy = 1'b1;
    pushExp(0, 32'hB00);
    applyStimulus(1);
    schedRdy = 1'b0;
    spawnThread(3, 32'hC00);
    applyStimulus(1);
    schedRdy = 1'b1;
    pushExp(3, 32'hC00);
    applyStimulus(1);

    // Reset mid-stream discards everything at once.
    rstN = 1'b0;
    #1;
    checkOutput("midrst_vld", 64'(schedVld), 64'd1);
    checkOutput("midrst_tid", 64'(schedTid), 64'd0);
    checkOutput("midrst_pc", 64'(schedPc), 64'h0);
    checkOutput("midrst_mask", 64'(activeMask), 64'h01);
    applyStimulus(2);
    rstN = 1'b1;
    pushExp(0, 32'h0); pushExp(0, 32'h4);
    applyStimulus(2);
    schedRdy = 1'b0;
    checkOutput("post_rst_mask", 64'(activeMask), 64'h01);

    applyStimulus(2);
    checkOutput("sb_drain", 64'(expQ.size()), 64'd0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/mrv1_imt_sched.md
MRV1_IMT_SCHED -- requirements
Module: mrv1_imt_sched

Interface
REQ-001 SHALL have parameter NUM_TW_P, default 8, number of hardware threads (power of two, >=2); TID = $clog2(NUM_TW_P).
REQ-002 SHALL have parameter RESET_PC_P, default 32'h0000_0000, boot PC of thread 0.
REQ-003 SHALL have clk_i  in  1  sole clock, rising edge.
REQ-004 SHALL have rst_ni  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have sched_vld_o  out  1  fetch request valid.
REQ-006 SHALL have sched_rdy_i  in  1  fetch accepted (IMEM ready and fetch queue not full).
REQ-007 SHALL have sched_tid_o  out  TID  thread of request; sched_pc_o  out  32  PC of request.
REQ-008 SHALL have dec_j_pc_vld_i  in  1, dec_tid_i  in  TID, dec_j_pc_i  in  32  decode jump redirect.
REQ-009 SHALL have exec_b_pc_vld_i  in  1, exec_tid_i  in  TID, exec_b_pc_i  in  32  execute branch redirect.
REQ-010 SHALL have wstall_vld_i  in  1, wstall_tid_i  in  TID  park thread; wake_vld_i  in  1, wake_tid_i  in  TID  unpark thread.
REQ-011 SHALL have th_ctl_tspawn_vld_i  in  1, th_ctl_texit_vld_i  in  1, th_ctl_tid_i  in  TID, th_ctl_tspawn_pc_i  in  32  thread spawn/exit.
REQ-012 SHALL have active_mask_o  out  NUM_TW_P  per-thread active bits, registered.

Function
REQ-013 SHALL hold per thread: active bit, stalled bit, 32-bit PC; plus TID-wide last-grant pointer.
REQ-014 SHALL define eligible[t] = active[t] & ~stalled[t]; sched_vld_o = |eligible, combinational from registered state only.
REQ-015 SHALL select the first eligible thread searching from last_grant+1 upward, wrapping modulo NUM_TW_P; sched_pc_o = pc[sched_tid_o].
REQ-016 SHALL treat a fetch as issued only on sched_vld_o & sched_rdy_i; no output stability is required while sched_rdy_i is low.
REQ-017 On issue SHALL set pc[tid] <= pc[tid]+4 (wraps modulo 2^32) and last_grant <= tid, visible next cycle.
REQ-018 SHALL apply exec redirect as pc[exec_tid_i] <= exec_b_pc_i next cycle; decode redirect likewise.
REQ-019 Per thread, PC write priority SHALL be: spawn > exec redirect > decode redirect > issue increment.
REQ-020 Redirects to different threads in the same cycle SHALL both take effect.
REQ-021 Redirects targeting an inactive thread SHALL be ignored.
REQ-022 wstall SHALL set stalled[tid]; wake SHALL clear it; same tid same cycle: wake wins.
REQ-023 A stall on the thread issued the same cycle SHALL not cancel that issue; thread becomes ineligible next cycle.
REQ-024 Spawn SHALL set active, clear stalled, load pc <= th_ctl_tspawn_pc_i; spawn to an already-active thread overwrites its PC.
REQ-025 Exit SHALL clear active[tid]; exit and spawn same cycle: spawn wins; exit on the issued thread does not cancel that issue.
REQ-026 With no eligible thread, sched_vld_o SHALL be 0 and state SHALL change only via control inputs.

Reset
REQ-027 While rst_ni is low: active=0..01, stalled=0, pc[0]=RESET_PC_P, pc[others]=0, last_grant=NUM_TW_P-1.
REQ-028 Reset outputs: sched_vld_o=1, sched_tid_o=0, sched_pc_o=RESET_PC_P, active_mask_o=1; assertion mid-operation discards all pending state immediately.

Configuration
REQ-029 Macro MRV1_IMT_WSTALL_EN defined: stall/wake per REQ-022/023.
REQ-030 Macro undefined: wstall_*/wake_* inputs ignored, stalled bits constant 0, no stall storage synthesized.

Verification
REQ-031 Reset release, rdy=1 for 3 cycles -> tid 0 PCs 0x0, 0x4, 0x8; active_mask_o=8'h01.
REQ-032 Spawn tid 3 pc 0x100, tid 5 pc 0x200, rdy=1 -> grants rotate 0,3,5,0,3 with PCs 0xC,0x100,0x200,0x10,0x104.
REQ-033 Same cycle: exec redirect tid 3 ->0x400, decode redirect tid 3 ->0x500, tid 3 issued -> pc[3]=0x400 next cycle.
REQ-034 wstall tid 0 with tids 0,3 active -> only tid 3 granted; wake tid 0 -> tid 0 granted again at its held PC (MRV1_IMT_WSTALL_EN defined).
REQ-035 Exit tid 0 while only thread active -> sched_vld_o=0 next cycle; spawn tid 0 pc 0xFFFF_FFFC then two issues -> PCs 0xFFFF_FFFC, 0x0000_0000.
REQ-036 rdy=0 for 4 cycles with tids 0,3 eligible -> no PC or pointer change; rst_ni pulse mid-stream -> REQ-028 values.
